// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-side
// and a data-side client. A three-state FSM (IDLE, BUSY_I, BUSY_D) grants
// one client at a time, latches that client's request and drives the memory
// only from the latched copy until the memory answers with mem_resp.
// The data side wins a simultaneous request unless ARB_ROUND_ROBIN_EN is
// defined, in which case a tie goes to the client that was not granted last.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic        imem_write,
  input  logic [3:0]  imem_byte_enable,
  input  logic [31:0] imem_address,
  input  logic [31:0] imem_wdata,
  output logic        imem_resp,
  output logic [31:0] imem_rdata,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_resp,
  output logic [31:0] dmem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_req_i;
  logic        w_req_d;
  logic        w_pick_d;
  logic        w_grant_i;
  logic        w_grant_d;

  logic        r_read;
  logic        r_write;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  assign w_req_i = imem_read | imem_write;
  assign w_req_d = dmem_read | dmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data side was granted last, 0 = instruction side
  logic r_last_d;

  // On a tie the data side wins only if the instruction side was served last
  assign w_pick_d = w_req_d & (~w_req_i | ~r_last_d);

  // Remember which client received the most recent grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  assign w_pick_d = w_req_d;
`endif

  // Arbitration, next-state and response routing
  always_comb begin
    w_next     = r_state;
    w_grant_i  = 1'b0;
    w_grant_d  = 1'b0;
    imem_resp  = 1'b0;
    imem_rdata = 32'd0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next    = BUSY_D;
          w_grant_d = 1'b1;
        end else if (w_req_i) begin
          w_next    = BUSY_I;
          w_grant_i = 1'b1;
        end
      end
      BUSY_I: begin
        if (mem_resp) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_rdata;
          w_next     = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_resp) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem_rdata;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the granted request; strobes drop when the memory answers so the
  // memory sees nothing while the FSM sits in IDLE. Write beats read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_be    <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_grant_d) begin
      r_read  <= dmem_read & ~dmem_write;
      r_write <= dmem_write;
      r_be    <= dmem_byte_enable;
      r_addr  <= dmem_address;
      r_wdata <= dmem_wdata;
    end else if (w_grant_i) begin
      r_read  <= imem_read & ~imem_write;
      r_write <= imem_write;
      r_be    <= imem_byte_enable;
      r_addr  <= imem_address;
      r_wdata <= imem_wdata;
    end else if ((r_state != IDLE) && mem_resp) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  assign mem_read        = r_read;
  assign mem_write       = r_write;
  assign mem_byte_enable = r_be;
  assign mem_address     = r_addr;
  assign mem_wdata       = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single-client transactions
// followed by hand-written sequences for contention, mid-transaction input
// changes and reset during a busy transaction. Inputs change on the falling
// edge and outputs are sampled 1 ns later.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_read, imem_write;
  logic [3:0]  imem_byte_enable;
  logic [31:0] imem_address, imem_wdata;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        dmem_read, dmem_write;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_address, dmem_wdata;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        is_d;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        exp_mr;
    logic        exp_mw;
  } txn_t;

  txn_t tbl [5];

  mem_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .imem_read        (imem_read),
    .imem_write       (imem_write),
    .imem_byte_enable (imem_byte_enable),
    .imem_address     (imem_address),
    .imem_wdata       (imem_wdata),
    .imem_resp        (imem_resp),
    .imem_rdata       (imem_rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte_enable  (mem_byte_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_resp         (mem_resp),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    imem_read = 0; imem_write = 0; imem_byte_enable = 0; imem_address = 0; imem_wdata = 0;
    dmem_read = 0; dmem_write = 0; dmem_byte_enable = 0; dmem_address = 0; dmem_wdata = 0;
  endtask

  // Assert reset on a falling edge, check outputs, release on the next one
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mem_read",  mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr",  mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be",    mem_byte_enable, 0);
    chk("rst_imem_resp", imem_resp, 0);
    chk("rst_dmem_resp", dmem_resp, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_txn(input txn_t t);
    logic r_g, r_o;
    logic [31:0] d_g, d_o;
    @(negedge clk);
    if (t.is_d) begin
      dmem_read = t.rd; dmem_write = t.wr; dmem_byte_enable = t.be;
      dmem_address = t.addr; dmem_wdata = t.wdata;
    end else begin
      imem_read = t.rd; imem_write = t.wr; imem_byte_enable = t.be;
      imem_address = t.addr; imem_wdata = t.wdata;
    end
    #1;
    chk("idle_mem_read",  mem_read, 0);
    chk("idle_mem_write", mem_write, 0);
    @(negedge clk);
    #1;
    chk("txn_mem_read",  mem_read, t.exp_mr);
    chk("txn_mem_write", mem_write, t.exp_mw);
    chk("txn_mem_addr",  mem_address, t.addr);
    chk("txn_mem_be",    mem_byte_enable, t.be);
    chk("txn_mem_wdata", mem_wdata, t.wdata);
    for (int c = 1; c < t.lat; c++) begin
      chk("txn_wait_imem_resp", imem_resp, 0);
      chk("txn_wait_dmem_resp", dmem_resp, 0);
      @(negedge clk);
      #1;
      chk("txn_hold_mem_read", mem_read, t.exp_mr);
    end
    mem_resp = 1'b1;
    mem_rdata = t.rdata;
    #1;
    r_g = t.is_d ? dmem_resp : imem_resp;
    r_o = t.is_d ? imem_resp : dmem_resp;
    d_g = t.is_d ? dmem_rdata : imem_rdata;
    d_o = t.is_d ? imem_rdata : dmem_rdata;
    chk("txn_resp_granted",   r_g, 1);
    chk("txn_rdata_granted",  d_g, t.rdata);
    chk("txn_resp_other",     r_o, 0);
    chk("txn_rdata_other",    d_o, 0);
    @(negedge clk);
    mem_resp = 1'b0;
    mem_rdata = 32'd0;
    clear_reqs();
    #1;
    chk("post_mem_read",  mem_read, 0);
    chk("post_mem_write", mem_write, 0);
    chk("post_imem_resp", imem_resp, 0);
    chk("post_dmem_resp", dmem_resp, 0);
  endtask

  initial begin
    logic exp_d;
    logic [31:0] exp_a;

    //          is_d rd wr be       addr          wdata         lat rdata         mr mw
    tbl[0] = '{1'b0, 1, 0, 4'hF,    32'h00000060, 32'h00000000, 3, 32'h00000013, 1, 0};
    tbl[1] = '{1'b1, 0, 1, 4'b0011, 32'h00002000, 32'hDEADBEEF, 1, 32'h00000000, 0, 1};
    tbl[2] = '{1'b1, 1, 1, 4'hF,    32'h00000040, 32'h12345678, 2, 32'h00000000, 0, 1};
    tbl[3] = '{1'b0, 0, 1, 4'b1000, 32'h00000104, 32'h0000A5A5, 1, 32'h00000000, 0, 1};
    tbl[4] = '{1'b1, 1, 0, 4'hF,    32'h00008000, 32'h00000000, 4, 32'hCAFEF00D, 1, 0};

    rst = 1'b1;
    mem_resp = 1'b0;
    mem_rdata = 32'd0;
    clear_reqs();

    do_reset();
    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // Simultaneous requests straight after reset: data side first
    do_reset();
    imem_read = 1; imem_address = 32'h100; imem_byte_enable = 4'hF;
    dmem_write = 1; dmem_address = 32'h2000; dmem_byte_enable = 4'b0011; dmem_wdata = 32'hDEADBEEF;
    @(negedge clk); #1;
    chk("pri_d_mem_write", mem_write, 1);
    chk("pri_d_mem_read",  mem_read, 0);
    chk("pri_d_addr",      mem_address, 32'h2000);
    chk("pri_d_wdata",     mem_wdata, 32'hDEADBEEF);
    chk("pri_d_be",        mem_byte_enable, 4'b0011);
    mem_resp = 1; #1;
    chk("pri_d_resp",      dmem_resp, 1);
    chk("pri_d_iresp",     imem_resp, 0);
    @(negedge clk);
    mem_resp = 0; dmem_write = 0; #1;
    chk("pri_gap_read",    mem_read, 0);
    chk("pri_gap_write",   mem_write, 0);
    @(negedge clk); #1;
    chk("pri_i_mem_read",  mem_read, 1);
    chk("pri_i_addr",      mem_address, 32'h100);
    mem_resp = 1; mem_rdata = 32'h55; #1;
    chk("pri_i_resp",      imem_resp, 1);
    chk("pri_i_rdata",     imem_rdata, 32'h55);
    chk("pri_i_drdata",    dmem_rdata, 0);
    @(negedge clk);
    mem_resp = 0; mem_rdata = 0; clear_reqs();

    // Both clients requesting continuously from reset
    do_reset();
    imem_read = 1; imem_address = 32'h100;
    dmem_read = 1; dmem_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      exp_a = exp_d ? 32'h200 : 32'h100;
      @(negedge clk); #1;
      chk("cont_mem_read", mem_read, 1);
      chk("cont_addr",     mem_address, exp_a);
      mem_resp = 1; mem_rdata = k; #1;
      chk("cont_dresp",    dmem_resp, exp_d);
      chk("cont_iresp",    imem_resp, !exp_d);
      @(negedge clk);
      mem_resp = 0; #1;
      chk("cont_gap_read", mem_read, 0);
    end
    clear_reqs();

    // Address change while busy must not reach the memory
    @(negedge clk);
    dmem_read = 1; dmem_address = 32'h2000; dmem_byte_enable = 4'hF;
    @(negedge clk); #1;
    chk("hold_addr0", mem_address, 32'h2000);
    dmem_address = 32'h3000;
    @(negedge clk); #1;
    chk("hold_addr1", mem_address, 32'h2000);
    @(negedge clk); #1;
    chk("hold_addr2", mem_address, 32'h2000);
    mem_resp = 1; #1;
    chk("hold_resp",  dmem_resp, 1);
    @(negedge clk);
    mem_resp = 0; clear_reqs();

    // Reset during BUSY_I, then a late mem_resp
    @(negedge clk);
    imem_read = 1; imem_address = 32'h60; imem_byte_enable = 4'hF;
    @(negedge clk); #1;
    chk("rstb_mem_read", mem_read, 1);
    rst = 1; imem_read = 0; #1;
    chk("rstb_read_cleared", mem_read, 0);
    chk("rstb_addr_cleared", mem_address, 0);
    @(negedge clk);
    rst = 0; mem_resp = 1; mem_rdata = 32'h13; #1;
    chk("rstb_no_iresp",  imem_resp, 0);
    chk("rstb_no_dresp",  dmem_resp, 0);
    chk("rstb_irdata",    imem_rdata, 0);
    @(negedge clk); #1;
    chk("rstb_idle_read", mem_read, 0);
    chk("rstb_idle_resp", imem_resp, 0);
    mem_resp = 0; mem_rdata = 0;

    // A normal transaction afterwards shows the FSM is back in IDLE
    run_txn(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all ports SHALL be as listed below.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- imem_read  in  1  instruction-side read request; held until imem_resp
- imem_write  in  1  instruction-side write request; held until imem_resp
- imem_byte_enable  in  4  instruction-side byte lanes
- imem_address  in  32  instruction-side byte address
- imem_wdata  in  32  instruction-side write data
- imem_resp  out  1  one-cycle completion pulse to the instruction side
- imem_rdata  out  32  instruction-side read data, valid with imem_resp
- dmem_read  in  1  data-side read request; held until dmem_resp
- dmem_write  in  1  data-side write request; held until dmem_resp
- dmem_byte_enable  in  4  data-side byte lanes
- dmem_address  in  32  data-side byte address
- dmem_wdata  in  32  data-side write data
- dmem_resp  out  1  one-cycle completion pulse to the data side
- dmem_rdata  out  32  data-side read data, valid with dmem_resp
- mem_read  out  1  read request to the single-port memory
- mem_write  out  1  write request to the single-port memory
- mem_byte_enable  out  4  byte lanes to memory
- mem_address  out  32  address to memory
- mem_wdata  out  32  write data to memory
- mem_resp  in  1  memory completion, any latency of 1 or more cycles
- mem_rdata  in  32  memory read data, valid with mem_resp

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, BUSY_I and BUSY_D.
REQ-003 In IDLE, the FSM SHALL go to BUSY_D if dmem_read or dmem_write is high, else to BUSY_I if imem_read or imem_write is high, else stay in IDLE.
REQ-004 On the IDLE-to-BUSY edge, the block SHALL register the granted client's read, write, byte_enable, address and wdata; mem_* SHALL be driven only from these registers.
REQ-005 If a client asserts read and write together, write SHALL win: the captured read bit SHALL be 0.
REQ-006 In IDLE, mem_read and mem_write SHALL be 0; in BUSY_x, they SHALL hold the captured values until mem_resp.
REQ-007 In BUSY_x with mem_resp=1, x_resp SHALL be 1 and x_rdata SHALL equal mem_rdata in that same cycle, and the next state SHALL be IDLE.
REQ-008 x_resp SHALL never be high outside BUSY_x; an ungranted client's rdata SHALL be 0.
REQ-009 mem_resp while in IDLE SHALL be ignored: no resp is generated and the state is unchanged.
REQ-010 Minimum latency SHALL be request cycle to resp = 2 cycles; after any response there SHALL be exactly one IDLE cycle before the next grant.
REQ-011 Changes on a granted client's inputs during BUSY SHALL have no effect on mem_*.

Reset
REQ-012 Asserting rst SHALL immediately force IDLE, with all outputs and captured registers at 0 and last_grant=I; an in-flight transaction SHALL be abandoned with no resp.
REQ-013 After rst deasserts, the first arbitration SHALL occur on the first rising edge with rst low.

Configuration
REQ-014 With ARB_ROUND_ROBIN_EN defined, if both clients request in IDLE, the grant SHALL go to the client not in last_grant; last_grant SHALL update on every grant.
REQ-015 Without ARB_ROUND_ROBIN_EN, dmem SHALL always win per REQ-003, and no last_grant register SHALL exist.

Verification
REQ-016 The bench SHALL cover: reset, then imem_read addr 0x60 with mem_resp 3 cycles later and mem_rdata 0x00000013 -> imem_resp pulses once with imem_rdata 0x00000013, mem_read drops the cycle after.
REQ-017 The bench SHALL cover: imem_read 0x100 and dmem_write 0x2000 (be 4'b0011, wdata 0xDEADBEEF) in the same cycle, fixed priority -> dmem served first with mem_wdata 0xDEADBEEF and mem_byte_enable 4'b0011, then imem.
REQ-018 The bench SHALL cover: with ARB_ROUND_ROBIN_EN, both clients requesting continuously after reset -> grants D, I, D, I with one IDLE cycle between each.
REQ-019 The bench SHALL cover: dmem_address changes from 0x2000 to 0x3000 mid-BUSY_D -> mem_address stays 0x2000 until mem_resp.
REQ-020 The bench SHALL cover: rst pulses during BUSY_I, then mem_resp arrives -> no imem_resp, mem_read is 0, and the state is IDLE.
REQ-021 The bench SHALL cover: dmem_read and dmem_write both high at 0x40 -> mem_write=1 and mem_read=0.
